// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg
//   Definitions shared by the multi-cycle controller and the datapath:
//   FSM state encoding, opcode constants and ALU operation codes.
//   No ports (package).
package mc_controller_pkg;

    // Controller state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // Instruction encodings
    localparam logic [6:0]  OP_RTYPE    = 7'b0110011;
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    // ALU operation select codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    function automatic logic [6:0] opcode_of(input logic [31:0] insn);
        return insn[6:0];
    endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// alu_decoder
//   Combinational R-type decoder: maps {funct7, funct3} to an ALU
//   operation code and flags encodings the ALU does not support.
//   Ports:
//     funct7      in  7  instruction bits [31:25]
//     funct3      in  3  instruction bits [14:12]
//     alu_control out 4  ALU operation select (ALU_AND when illegal)
//     legal       out 1  1 when the combination is a supported operation
module alu_decoder
    import mc_controller_pkg::*;
(
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic [3:0] alu_control,
    output logic       legal
);

    always_comb begin
        alu_control = ALU_AND;
        legal       = 1'b1;
        case ({funct7, funct3})
            {7'b0000000, 3'b000}: alu_control = ALU_ADD;
            {7'b0100000, 3'b000}: alu_control = ALU_SUB;
            {7'b0000000, 3'b001}: alu_control = ALU_SLL;
            {7'b0000000, 3'b010}: alu_control = ALU_SLT;
            {7'b0000000, 3'b011}: alu_control = ALU_SLTU;
            {7'b0000000, 3'b100}: alu_control = ALU_XOR;
            {7'b0000000, 3'b101}: alu_control = ALU_SRL;
            {7'b0100000, 3'b101}: alu_control = ALU_SRA;
            {7'b0000000, 3'b110}: alu_control = ALU_OR;
            {7'b0000000, 3'b111}: alu_control = ALU_AND;
            default:              legal       = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller
//   Multi-cycle instruction controller: IDLE -> FETCH -> DECODE -> EXEC -> WB.
//   Supports the R-type ALU group; EBREAK halts cleanly, anything else
//   halts with the sticky illegal flag set. HALT is left only by reset.
//   Ports:
//     clock       in  1   rising-edge clock
//     reset       in  1   asynchronous, active-low reset
//     run         in  1   1 = keep executing, 0 = park in IDLE after current insn
//     imem_req    out 1   fetch request, high for the whole FETCH state
//     imem_ack    in  1   imem_rdata valid this cycle
//     imem_rdata  in  32  fetched instruction word
//     pc          out 32  current instruction / fetch address
//     ir          out 32  instruction register
//     alu_control out 4   ALU select, valid in EXEC and WB, else 0
//     regwrite    out 1   register-file write enable (WB only)
//     retired     out 1   one-cycle pulse per completed instruction
//     instret     out 32  retired instruction count
//     halted      out 1   high in HALT
//     illegal     out 1   sticky; HALT reached via an unsupported encoding
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [3:0]  alu_control,
    output logic        regwrite,
    output logic        retired,
    output logic [31:0] instret,
    output logic        halted,
    output logic        illegal
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [3:0] dec_alu;
    logic       dec_legal;
    logic       is_ebreak;
    logic       is_supported;

    alu_decoder u_alu_decoder (
        .funct7      (ir[31:25]),
        .funct3      (ir[14:12]),
        .alu_control (dec_alu),
        .legal       (dec_legal)
    );

    assign is_ebreak    = (ir == EBREAK_WORD);
    assign is_supported = (opcode_of(ir) == OP_RTYPE) && dec_legal;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (run) state_nxt = ST_FETCH;
            ST_FETCH:  if (imem_ack) state_nxt = ST_DECODE;
            // EBREAK is checked first; it is not an R-type word anyway.
            ST_DECODE: state_nxt = (!is_ebreak && is_supported) ? ST_EXEC : ST_HALT;
            ST_EXEC:   state_nxt = ST_WB;
            // run is only sampled here, so an instruction in flight always completes.
            ST_WB:     state_nxt = run ? ST_FETCH : ST_IDLE;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            ir      <= 32'h0;
            instret <= 32'h0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH && imem_ack)
                ir <= imem_rdata;
            if (state == ST_WB) begin
                pc      <= pc + 32'd4;
                instret <= instret + 32'd1;
            end
            if (state == ST_DECODE && state_nxt == ST_HALT && !is_ebreak)
                illegal <= 1'b1;
        end
    end

    assign imem_req    = (state == ST_FETCH);
    assign regwrite    = (state == ST_WB);
    assign retired     = (state == ST_WB);
    assign halted      = (state == ST_HALT);
    assign alu_control = (state == ST_EXEC || state == ST_WB) ? dec_alu : 4'b0000;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
//   Directed bench for mc_controller: one task per scenario, each with its
//   own expected values worked out by hand from the instruction timing.
module tb_mc_controller;

    logic        clock;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [3:0]  alu_control;
    logic        regwrite;
    logic        retired;
    logic [31:0] instret;
    logic        halted;
    logic        illegal;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [31:0] I_ADD    = 32'h0020_81B3;
    localparam logic [31:0] I_SUB    = 32'h4020_81B3;
    localparam logic [31:0] I_XOR    = 32'h0020_C1B3;
    localparam logic [31:0] I_ADDI   = 32'h0000_0013;
    localparam logic [31:0] I_EBREAK = 32'h0010_0073;

    mc_controller dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .ir          (ir),
        .alu_control (alu_control),
        .regwrite    (regwrite),
        .retired     (retired),
        .instret     (instret),
        .halted      (halted),
        .illegal     (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hold reset for two edges, apply the given inputs, release reset.
    // On return the design is in IDLE ("cycle 0"); the next edge starts cycle 1.
    task automatic do_reset(input logic r, input logic a, input logic [31:0] w);
        reset      = 1'b0;
        run        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        repeat (2) step();
        run        = r;
        imem_ack   = a;
        imem_rdata = w;
        reset      = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b1; imem_ack = 1'b1; imem_rdata = I_ADD;
        repeat (3) step();
        total_cnt++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want %h", pc, 32'h0); else pass_cnt++;
        total_cnt++; if (ir !== 32'h0) $display("FAIL reset_ir got %h want %h", ir, 32'h0); else pass_cnt++;
        total_cnt++; if (instret !== 32'h0) $display("FAIL reset_instret got %h want 0", instret); else pass_cnt++;
        total_cnt++;
        if ({imem_req, regwrite, retired, halted, illegal, alu_control} !== 9'b0)
            $display("FAIL reset_outputs got %b want 000000000", {imem_req, regwrite, retired, halted, illegal, alu_control});
        else pass_cnt++;
    endtask

    task automatic test_add();
        do_reset(1'b1, 1'b1, I_ADD);
        step(); // cycle 1: FETCH
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL add_req_c1 got %b want 1", imem_req); else pass_cnt++;
        total_cnt++; if (pc !== 32'h0) $display("FAIL add_fetch_pc got %h want 0", pc); else pass_cnt++;
        step(); // cycle 2: DECODE
        total_cnt++; if (ir !== I_ADD) $display("FAIL add_ir got %h want %h", ir, I_ADD); else pass_cnt++;
        total_cnt++; if (alu_control !== 4'b0000) $display("FAIL add_alu_decode got %b want 0000", alu_control); else pass_cnt++;
        step(); // cycle 3: EXEC
        total_cnt++; if ({regwrite, alu_control} !== 5'b0_0010) $display("FAIL add_exec got %b want 00010", {regwrite, alu_control}); else pass_cnt++;
        step(); // cycle 4: WB
        total_cnt++;
        if ({regwrite, retired, alu_control} !== 6'b11_0010)
            $display("FAIL add_wb got %b want 110010", {regwrite, retired, alu_control});
        else pass_cnt++;
        total_cnt++; if (pc !== 32'h0) $display("FAIL add_pc_in_wb got %h want 0", pc); else pass_cnt++;
        step(); // cycle 5: FETCH of next instruction
        total_cnt++; if (pc !== 32'h4) $display("FAIL add_pc got %h want 4", pc); else pass_cnt++;
        total_cnt++; if (instret !== 32'h1) $display("FAIL add_instret got %h want 1", instret); else pass_cnt++;
        total_cnt++; if ({imem_req, regwrite, retired} !== 3'b100) $display("FAIL add_refetch got %b want 100", {imem_req, regwrite, retired}); else pass_cnt++;
    endtask

    task automatic test_ack_delay();
        int req_cnt = 0;
        int ret_cyc = -1;
        logic [3:0] wb_alu = 4'hF;
        do_reset(1'b1, 1'b0, I_SUB);
        for (int c = 1; c <= 20 && ret_cyc < 0; c++) begin
            step();
            if (imem_req) req_cnt++;
            if (retired) begin
                ret_cyc = c;
                wb_alu  = alu_control;
            end
            imem_ack = (c >= 4);
        end
        total_cnt++; if (req_cnt != 4) $display("FAIL sub_req_cycles got %0d want 4", req_cnt); else pass_cnt++;
        total_cnt++; if (ret_cyc != 7) $display("FAIL sub_retire_cycle got %0d want 7", ret_cyc); else pass_cnt++;
        total_cnt++; if (wb_alu !== 4'b0110) $display("FAIL sub_alu got %b want 0110", wb_alu); else pass_cnt++;
    endtask

    task automatic test_illegal();
        int wr_cnt = 0;
        do_reset(1'b1, 1'b1, I_ADDI);
        for (int c = 1; c <= 6; c++) begin
            step();
            if (regwrite || retired) wr_cnt++;
        end
        total_cnt++; if (wr_cnt != 0) $display("FAIL addi_regwrite got %0d pulses want 0", wr_cnt); else pass_cnt++;
        total_cnt++; if ({halted, illegal} !== 2'b11) $display("FAIL addi_halt got %b want 11", {halted, illegal}); else pass_cnt++;
        total_cnt++; if (pc !== 32'h0) $display("FAIL addi_pc got %h want 0", pc); else pass_cnt++;
        total_cnt++; if ({imem_req, alu_control} !== 5'b0) $display("FAIL addi_outputs got %b want 00000", {imem_req, alu_control}); else pass_cnt++;
        total_cnt++; if (instret !== 32'h0) $display("FAIL addi_instret got %h want 0", instret); else pass_cnt++;
    endtask

    task automatic test_ebreak();
        int bad = 0;
        do_reset(1'b1, 1'b1, I_EBREAK);
        repeat (3) step(); // cycle 3: HALT
        total_cnt++; if ({halted, illegal} !== 2'b10) $display("FAIL ebreak_halt got %b want 10", {halted, illegal}); else pass_cnt++;
        for (int c = 0; c < 8; c++) begin
            run = c[0];
            step();
            if (!halted || illegal || imem_req || regwrite || pc !== 32'h0) bad++;
        end
        total_cnt++; if (bad != 0) $display("FAIL ebreak_terminal got %0d bad cycles want 0", bad); else pass_cnt++;
    endtask

    task automatic test_reset_in_exec();
        int wr_cnt = 0;
        do_reset(1'b1, 1'b1, I_ADD);
        repeat (7) step(); // cycle 7: EXEC of second instruction
        total_cnt++; if ({pc, alu_control} !== {32'h4, 4'b0010}) $display("FAIL rst_exec_pre got pc %h alu %b want pc 4 alu 0010", pc, alu_control); else pass_cnt++;
        run   = 1'b0;
        reset = 1'b0;
        #1;
        total_cnt++; if (pc !== 32'h0) $display("FAIL rst_exec_pc got %h want 0", pc); else pass_cnt++;
        total_cnt++; if (instret !== 32'h0) $display("FAIL rst_exec_instret got %h want 0", instret); else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            step();
            if (regwrite || retired) wr_cnt++;
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (regwrite || retired || imem_req) wr_cnt++;
        end
        total_cnt++; if (wr_cnt != 0) $display("FAIL rst_exec_activity got %0d want 0", wr_cnt); else pass_cnt++;
        total_cnt++; if ({pc, instret} !== 64'h0) $display("FAIL rst_exec_idle got pc %h instret %h want 0 0", pc, instret); else pass_cnt++;
    endtask

    task automatic test_run_drop();
        int req_cnt = 0;
        do_reset(1'b1, 1'b1, I_XOR);
        repeat (2) step(); // cycle 2: DECODE
        run = 1'b0;
        step(); // cycle 3: EXEC
        total_cnt++; if (alu_control !== 4'b0011) $display("FAIL drop_exec_alu got %b want 0011", alu_control); else pass_cnt++;
        step(); // cycle 4: WB
        total_cnt++; if ({regwrite, retired} !== 2'b11) $display("FAIL drop_retire got %b want 11", {regwrite, retired}); else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
            step();
            if (imem_req) req_cnt++;
        end
        total_cnt++; if (req_cnt != 0) $display("FAIL drop_idle_req got %0d want 0", req_cnt); else pass_cnt++;
        total_cnt++; if ({pc, instret} !== {32'h4, 32'h1}) $display("FAIL drop_counts got pc %h instret %h want 4 1", pc, instret); else pass_cnt++;
        run = 1'b1;
        step(); // FETCH resumes
        total_cnt++; if ({imem_req, pc} !== {1'b1, 32'h4}) $display("FAIL drop_resume got req %b pc %h want 1 4", imem_req, pc); else pass_cnt++;
    endtask

    // Further decode vectors: each word is fetched once and inspected at cycle 3.
    task automatic test_decode_table();
        logic [31:0] words [4] = '{32'h0020_91B3, 32'h4020_D1B3, 32'h0020_B1B3, 32'h0200_81B3};
        logic [3:0]  alus  [4] = '{4'b0100, 4'b0111, 4'b1001, 4'b0000};
        logic        legal [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            do_reset(1'b1, 1'b1, words[k]);
            repeat (3) step();
            total_cnt++;
            if ({halted, illegal, alu_control} !== {~legal[k], ~legal[k], alus[k]})
                $display("FAIL decode_%0d got %b want %b", k, {halted, illegal, alu_control}, {~legal[k], ~legal[k], alus[k]});
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_add();
        test_ack_delay();
        test_illegal();
        test_ebreak();
        test_reset_in_exec();
        test_run_drop();
        test_decode_table();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-004 run  input  1  level; 1 = execute instructions, 0 = park in IDLE after the current instruction.
REQ-005 imem_req  output  1  instruction fetch request; held high until imem_ack.
REQ-006 imem_ack  input  1  imem_rdata valid this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 pc  output  32  address of the current instruction, which is also the fetch address.
REQ-009 ir  output  32  instruction register; rs1/rs2/rd fields feed the datapath.
REQ-010 alu_control  output  4  ALU operation select to the datapath.
REQ-011 regwrite  output  1  register-file write enable to the datapath.
REQ-012 retired  output  1  one-cycle pulse per completed instruction.
REQ-013 instret  output  32  count of retired instructions.
REQ-014 halted  output  1  high in HALT state.
REQ-015 illegal  output  1  sticky; set when HALT is entered through an unsupported encoding.

Function
REQ-016 The FSM SHALL use states IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-017 IDLE SHALL go to FETCH on the next edge when run=1 and stay in IDLE otherwise.
REQ-018 FETCH SHALL assert imem_req and, on the edge with imem_ack=1, load ir<=imem_rdata and go to DECODE.
REQ-019 FETCH with imem_ack=0 SHALL hold all state, with no timeout.
REQ-020 DECODE SHALL go to EXEC when opcode=7'b0110011 and {funct7,funct3} is legal per REQ-023.
REQ-021 DECODE SHALL go to HALT with illegal=0 when ir=32'h0010_0073 (EBREAK).
REQ-022 DECODE SHALL go to HALT with illegal=1 for any other ir value.
REQ-023 The ALU map SHALL be, as funct7/funct3 -> alu_control:
- 0000000/000 ADD 0010; 0100000/000 SUB 0110; 0000000/001 SLL 0100; 0000000/010 SLT 1000
- 0000000/011 SLTU 1001; 0000000/100 XOR 0011; 0000000/101 SRL 0101; 0100000/101 SRA 0111
- 0000000/110 OR 0001; 0000000/111 AND 0000
- all other funct7/funct3 combinations are illegal.
REQ-024 alu_control SHALL hold the decoded value in EXEC and WB and SHALL be 4'b0000 in all other states.
REQ-025 EXEC SHALL last exactly one cycle and then go to WB.
REQ-026 WB SHALL last exactly one cycle, asserting regwrite=1 and retired=1 during that cycle.
REQ-027 On the edge leaving WB: pc<=pc+4 (mod 2^32), instret<=instret+1 (wraps at 2^32), next state FETCH if run=1 else IDLE.
REQ-028 regwrite SHALL be asserted only in WB.
REQ-029 pc and ir SHALL change only as specified in REQ-018 and REQ-027.
REQ-030 Latency SHALL be 4 cycles per instruction when imem_ack=1 in the first FETCH cycle; each ack-wait cycle adds 1.
REQ-031 Deassertion of run SHALL take effect only in IDLE or at WB exit; an instruction in flight always completes.
REQ-032 HALT SHALL be terminal until reset, with imem_req=0, regwrite=0 and halted=1.

Reset
REQ-033 While reset=0 the block SHALL hold state=IDLE, pc=RESET_PC, ir=0, instret=0, illegal=0, and all other outputs 0.
REQ-034 Reset asserted mid-instruction SHALL abort it without a regwrite pulse.
REQ-035 After reset release, the first FETCH SHALL use pc=RESET_PC.

Structure
REQ-036 A shared package SHALL hold the state enum, the opcode constants (OP_RTYPE, EBREAK word) and the ALU code constants, for reuse by the datapath.
REQ-037 Decode SHALL live in a combinational sub-module alu_decoder with inputs funct7 and funct3 and outputs alu_control and legal.

Verification
REQ-038 Reset, run=1, ack=1 always, imem=ADD x3,x1,x2 (32'h0020_81B3) -> imem_req at cycle 1, regwrite at cycle 4 with alu_control=0010, pc=4, instret=1.
REQ-039 SUB 32'h4020_81B3 with ack delayed 3 cycles -> imem_req held 4 cycles, alu_control=0110, retired 3 cycles later than with no delay.
REQ-040 32'h0000_0013 (ADDI) -> HALT, illegal=1, halted=1, no regwrite, pc unchanged.
REQ-041 32'h0010_0073 -> HALT with illegal=0; run toggling afterwards has no effect.
REQ-042 Reset pulsed low during EXEC -> no regwrite pulse, pc=RESET_PC, instret=0, state IDLE.
REQ-043 run dropped during DECODE -> instruction retires, then IDLE with imem_req=0; run=1 again resumes at pc+4.
